req_gnt_monitor: RTL and testbench
==================================

# req_gnt_monitor

Synthesizable multi-channel request/grant protocol monitor for simulation and on-chip debug. It tracks up to NUM_CH independent REQ/GNT pairs and flags three conditions per channel: a grant arriving later than MAX_WAIT cycles after its request, a grant with no outstanding request, and, in hold mode, a request withdrawn before its grant. It also keeps saturating violation and grant counters and the worst observed latency, so the bus-level grant-within-N-cycles check can run in hardware and on many channels at once.

## Interface

- NUM_CH, 4, number of monitored channels (1..32)
- MAX_WAIT, 4, maximum legal request-to-grant latency in cycles (1..255)
- REQ_HOLD, 1, 1 = requester must hold req high until granted; 0 = req is a pulse, latched by the monitor
- CNT_W, 16, width of viol_count and grant_count
- LAT_W, 8, width of max_latency (must hold MAX_WAIT+1)

- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  monitor enable; 0 forces all channels to IDLE, suppresses pulses, stats hold
- clear  in  1  synchronous clear of counters, max_latency and sticky errors (channel FSMs unaffected)
- req  in  NUM_CH  per-channel request
- gnt  in  NUM_CH  per-channel grant
- pending  out  NUM_CH  request outstanding (state WAIT or LATE)
- timeout_pulse  out  NUM_CH  one-cycle pulse: latency exceeded MAX_WAIT
- spurious_pulse  out  NUM_CH  one-cycle pulse: grant with no request
- drop_pulse  out  NUM_CH  one-cycle pulse: request withdrawn before grant (REQ_HOLD=1 only)
- err_sticky  out  NUM_CH  per-channel OR of all error pulses since reset/clear
- err_any  out  1  OR of err_sticky
- viol_count  out  CNT_W  total error events, saturating
- grant_count  out  CNT_W  completed request/grant pairs, saturating
- max_latency  out  LAT_W  largest completed latency, saturating at 2^LAT_W-1

## Operation

- Per-channel FSM: IDLE, WAIT, LATE; per-channel wait counter wcnt (LAT_W bits).
- Latency L = cycles from request-sample cycle r to grant-sample cycle; same-cycle req&gnt gives L=0.
- IDLE: req&gnt -> stay IDLE, grant_count+1, L=0. req&!gnt -> WAIT, wcnt=1. !req&gnt -> spurious_pulse.
- WAIT (wcnt = L of current cycle): gnt -> IDLE, grant_count+1, max_latency updated with wcnt. !gnt & wcnt==MAX_WAIT -> LATE, timeout_pulse. Otherwise wcnt+1.
- LATE: gnt -> IDLE, grant_count+1, max_latency updated with saturated wcnt; no further error. Otherwise wcnt+1, saturating.
- REQ_HOLD=1: !req & !gnt in WAIT/LATE -> IDLE, drop_pulse. REQ_HOLD=0: req level ignored while pending.
- A request high in the same cycle as the completing grant is consumed by that grant. The next request is the first req-high cycle after the grant cycle, so a held req re-requests back-to-back.
- viol_count adds the popcount of all error pulses raised in a cycle (multi-channel simultaneous events all counted), then saturates.
- Priority: reset > enable=0 > clear > normal. clear and an event in the same cycle: clear wins, and that event is not counted.

## Timing

- All outputs registered except err_any (combinational OR of err_sticky).
- Reset: FSMs IDLE, wcnt=0, all outputs 0.
- Pulses appear the cycle after the sampled condition, one cycle wide.
- Example, MAX_WAIT=4: req first high in cycle 10, no gnt. pending=1 from cycle 11, timeout_pulse=1 in cycle 15. gnt in cycle 14 is legal (L=4), pending=0 in cycle 15.
- Counters and max_latency update the cycle after the event.
- Reset or enable=0 mid-WAIT: channel returns to IDLE with no pulse.

## Test plan

- MAX_WAIT=4, ch0 req at cycle 10, gnt at cycle 14 -> no error, grant_count=1, max_latency=4, pending high in cycles 11-14.
- ch0 req at cycle 10, gnt at cycle 17 -> timeout_pulse in cycle 15 only, then grant_count=1, max_latency=7, viol_count=1, err_any=1.
- gnt on ch2 with req low, same cycle as a timeout on ch1 -> spurious_pulse[2] and timeout_pulse[1] together, viol_count +2.
- REQ_HOLD=1, req high for cycles 10-12 then low with no gnt -> drop_pulse in cycle 14; REQ_HOLD=0 with the same stimulus -> no drop, timeout in cycle 15.
- Held req with gnt every 3rd cycle -> back-to-back requests, L=2 each, no errors; clear asserted -> counters 0, pending unaffected.
- viol_count saturation with CNT_W=2 -> stays at 3; reset asserted mid-WAIT -> pending=0 next cycle, no pulse.

Source files
------------

// File: rtl/req_gnt_monitor_if.sv
// Request/grant bus bundle watched by req_gnt_monitor.
// The master modport drives req/gnt. The slave modport is the monitor side.
interface req_gnt_monitor_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned LAT_W  = 8
) ();
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] gnt;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] timeout_pulse;
    logic [NUM_CH-1:0] spurious_pulse;
    logic [NUM_CH-1:0] drop_pulse;
    logic [NUM_CH-1:0] err_sticky;
    logic              err_any;
    logic [CNT_W-1:0]  viol_count;
    logic [CNT_W-1:0]  grant_count;
    logic [LAT_W-1:0]  max_latency;

    modport master (
        output req, gnt,
        input  pending, timeout_pulse, spurious_pulse, drop_pulse, err_sticky, err_any,
        input  viol_count, grant_count, max_latency
    );

    modport slave (
        input  req, gnt,
        output pending, timeout_pulse, spurious_pulse, drop_pulse, err_sticky, err_any,
        output viol_count, grant_count, max_latency
    );
endinterface

// File: rtl/req_gnt_monitor.sv
// Multi-channel request/grant protocol monitor: late, spurious and dropped grants,
// plus saturating violation/grant counters and the worst completed latency.
module req_gnt_monitor #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned MAX_WAIT = 4,
    parameter bit          REQ_HOLD = 1'b1,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned LAT_W    = 8
) (
    input logic              clk,
    input logic              reset,
    input logic              enable,
    input logic              clear,
    req_gnt_monitor_if.slave bus
);
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StLate = 2'd2;

    localparam logic [LAT_W-1:0] MaxWaitL = LAT_W'(MAX_WAIT);
    localparam logic [LAT_W-1:0] LatMax   = {LAT_W{1'b1}};

    logic [1:0]        state_q [NUM_CH];
    logic [1:0]        state_d [NUM_CH];
    logic [LAT_W-1:0]  wcnt_q  [NUM_CH];
    logic [LAT_W-1:0]  wcnt_d  [NUM_CH];
    logic [LAT_W-1:0]  lat     [NUM_CH];
    logic [NUM_CH-1:0] done;
    logic [NUM_CH-1:0] tmo_d, spur_d, drop_d;
    logic [NUM_CH-1:0] pending_q, tmo_q, spur_q, drop_q, sticky_q;
    logic [CNT_W-1:0]  viol_q, viol_d, grant_q, grant_d;
    logic [LAT_W-1:0]  maxlat_q, maxlat_d;
    logic [7:0]        n_viol, n_grant;
    logic [CNT_W+7:0]  viol_sum, grant_sum;

    // Per-channel next state; done/lat report a completed request/grant pair.
    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            state_d[ch] = state_q[ch];
            wcnt_d[ch]  = wcnt_q[ch];
            lat[ch]     = '0;
            done[ch]    = 1'b0;
            tmo_d[ch]   = 1'b0;
            spur_d[ch]  = 1'b0;
            drop_d[ch]  = 1'b0;
            case (state_q[ch])
                StWait, StLate: begin
                    if (bus.gnt[ch]) begin
                        state_d[ch] = StIdle;
                        wcnt_d[ch]  = '0;
                        done[ch]    = 1'b1;
                        lat[ch]     = wcnt_q[ch];
                    end else if (REQ_HOLD && !bus.req[ch]) begin
                        state_d[ch] = StIdle;
                        wcnt_d[ch]  = '0;
                        drop_d[ch]  = 1'b1;
                    end else begin
                        if (state_q[ch] == StWait && wcnt_q[ch] == MaxWaitL) begin
                            state_d[ch] = StLate;
                            tmo_d[ch]   = 1'b1;
                        end
                        wcnt_d[ch] = (wcnt_q[ch] == LatMax) ? LatMax : wcnt_q[ch] + LAT_W'(1);
                    end
                end
                default: begin
                    state_d[ch] = StIdle;
                    wcnt_d[ch]  = '0;
                    if (bus.req[ch] && bus.gnt[ch]) begin
                        done[ch] = 1'b1;
                    end else if (bus.req[ch]) begin
                        state_d[ch] = StWait;
                        wcnt_d[ch]  = LAT_W'(1);
                    end else if (bus.gnt[ch]) begin
                        spur_d[ch] = 1'b1;
                    end
                end
            endcase
            if (!enable) begin
                state_d[ch] = StIdle;
                wcnt_d[ch]  = '0;
                done[ch]    = 1'b0;
                tmo_d[ch]   = 1'b0;
                spur_d[ch]  = 1'b0;
                drop_d[ch]  = 1'b0;
            end
        end
    end

    always_comb begin
        n_viol   = '0;
        n_grant  = '0;
        maxlat_d = maxlat_q;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            n_viol  = n_viol + 8'(tmo_d[ch]) + 8'(spur_d[ch]) + 8'(drop_d[ch]);
            n_grant = n_grant + 8'(done[ch]);
            if (done[ch] && lat[ch] > maxlat_d) begin
                maxlat_d = lat[ch];
            end
        end
        viol_sum  = (CNT_W+8)'(viol_q) + (CNT_W+8)'(n_viol);
        grant_sum = (CNT_W+8)'(grant_q) + (CNT_W+8)'(n_grant);
        viol_d    = (|viol_sum[CNT_W+7:CNT_W]) ? {CNT_W{1'b1}} : viol_sum[CNT_W-1:0];
        grant_d   = (|grant_sum[CNT_W+7:CNT_W]) ? {CNT_W{1'b1}} : grant_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                state_q[ch] <= StIdle;
                wcnt_q[ch]  <= '0;
            end
            pending_q <= '0;
            tmo_q     <= '0;
            spur_q    <= '0;
            drop_q    <= '0;
            sticky_q  <= '0;
            viol_q    <= '0;
            grant_q   <= '0;
            maxlat_q  <= '0;
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                state_q[ch]   <= state_d[ch];
                wcnt_q[ch]    <= wcnt_d[ch];
                pending_q[ch] <= (state_d[ch] != StIdle);
            end
            tmo_q  <= tmo_d;
            spur_q <= spur_d;
            drop_q <= drop_d;
            // Stats hold while disabled; clear discards same-cycle events.
            if (enable) begin
                if (clear) begin
                    sticky_q <= '0;
                    viol_q   <= '0;
                    grant_q  <= '0;
                    maxlat_q <= '0;
                end else begin
                    sticky_q <= sticky_q | tmo_d | spur_d | drop_d;
                    viol_q   <= viol_d;
                    grant_q  <= grant_d;
                    maxlat_q <= maxlat_d;
                end
            end
        end
    end

    assign bus.pending        = pending_q;
    assign bus.timeout_pulse  = tmo_q;
    assign bus.spurious_pulse = spur_q;
    assign bus.drop_pulse     = drop_q;
    assign bus.err_sticky     = sticky_q;
    assign bus.err_any        = |sticky_q;
    assign bus.viol_count     = viol_q;
    assign bus.grant_count    = grant_q;
    assign bus.max_latency    = maxlat_q;
endmodule

// File: tb/tb_req_gnt_monitor.sv
// Directed bench for req_gnt_monitor: hold mode, pulse mode and a 2-bit counter
// variant all see the same req/gnt stimulus.
module tb_req_gnt_monitor;
    logic       clk = 1'b0;
    logic       reset, enable, clear;
    logic [3:0] req, gnt;
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    req_gnt_monitor_if #(.NUM_CH(4), .CNT_W(16), .LAT_W(8)) bus_h ();
    req_gnt_monitor_if #(.NUM_CH(4), .CNT_W(16), .LAT_W(8)) bus_n ();
    req_gnt_monitor_if #(.NUM_CH(4), .CNT_W(2),  .LAT_W(8)) bus_s ();

    assign bus_h.req = req;
    assign bus_h.gnt = gnt;
    assign bus_n.req = req;
    assign bus_n.gnt = gnt;
    assign bus_s.req = req;
    assign bus_s.gnt = gnt;

    req_gnt_monitor #(.NUM_CH(4), .MAX_WAIT(4), .REQ_HOLD(1'b1), .CNT_W(16), .LAT_W(8)) dut_h (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .bus(bus_h.slave)
    );
    req_gnt_monitor #(.NUM_CH(4), .MAX_WAIT(4), .REQ_HOLD(1'b0), .CNT_W(16), .LAT_W(8)) dut_n (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .bus(bus_n.slave)
    );
    req_gnt_monitor #(.NUM_CH(4), .MAX_WAIT(4), .REQ_HOLD(1'b1), .CNT_W(2), .LAT_W(8)) dut_s (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .bus(bus_s.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; clear = 1'b0; req = '0; gnt = '0;
        tick(); tick();
        chk("rst_pending", 32'(bus_h.pending), 32'h0);
        chk("rst_viol", 32'(bus_h.viol_count), 32'h0);
        chk("rst_grant", 32'(bus_h.grant_count), 32'h0);
        chk("rst_maxlat", 32'(bus_h.max_latency), 32'h0);
        chk("rst_err_any", 32'(bus_h.err_any), 32'h0);
        reset = 1'b0;
        tick();

        // Legal grant at L = MAX_WAIT
        req = 4'b0001;
        tick(); chk("t1_pend_c1", 32'(bus_h.pending), 32'h1);
        tick(); tick(); tick();
        gnt = 4'b0001;
        chk("t1_pend_c4", 32'(bus_h.pending), 32'h1);
        tick(); req = '0; gnt = '0;
        chk("t1_pend_c5", 32'(bus_h.pending), 32'h0);
        chk("t1_tmo", 32'(bus_h.timeout_pulse), 32'h0);
        chk("t1_grant", 32'(bus_h.grant_count), 32'd1);
        chk("t1_maxlat", 32'(bus_h.max_latency), 32'd4);
        chk("t1_viol", 32'(bus_h.viol_count), 32'd0);

        // Late grant at L = 7
        req = 4'b0001;
        repeat (5) tick();
        chk("t2_tmo_c5", 32'(bus_h.timeout_pulse), 32'h1);
        chk("t2_viol", 32'(bus_h.viol_count), 32'd1);
        chk("t2_err_any", 32'(bus_h.err_any), 32'h1);
        chk("t2_sticky", 32'(bus_h.err_sticky), 32'h1);
        tick(); chk("t2_tmo_c6", 32'(bus_h.timeout_pulse), 32'h0);
        tick(); gnt = 4'b0001;
        tick(); req = '0; gnt = '0;
        chk("t2_grant", 32'(bus_h.grant_count), 32'd2);
        chk("t2_maxlat", 32'(bus_h.max_latency), 32'd7);
        chk("t2_viol_after", 32'(bus_h.viol_count), 32'd1);
        chk("t2_pend", 32'(bus_h.pending), 32'h0);

        // Spurious ch2 coincident with timeout ch1
        req = 4'b0010;
        repeat (4) tick();
        gnt = 4'b0100;
        tick();
        chk("t3_tmo", 32'(bus_h.timeout_pulse), 32'h2);
        chk("t3_spur", 32'(bus_h.spurious_pulse), 32'h4);
        chk("t3_viol", 32'(bus_h.viol_count), 32'd3);
        chk("t3_sat_viol", 32'(bus_s.viol_count), 32'd3);
        gnt = 4'b0010;
        tick(); req = '0; gnt = '0;
        chk("t3_grant", 32'(bus_h.grant_count), 32'd3);
        chk("t3_pend", 32'(bus_h.pending), 32'h0);
        chk("t3_maxlat", 32'(bus_h.max_latency), 32'd7);

        // Request withdrawn after three cycles
        req = 4'b0001;
        tick(); tick(); tick();
        req = '0;
        tick();
        chk("t4_drop_h", 32'(bus_h.drop_pulse), 32'h1);
        chk("t4_drop_n", 32'(bus_n.drop_pulse), 32'h0);
        chk("t4_pend_n", 32'(bus_n.pending), 32'h1);
        chk("t4_viol_h", 32'(bus_h.viol_count), 32'd4);
        chk("t4_sat_viol", 32'(bus_s.viol_count), 32'd3);
        tick();
        chk("t4_tmo_n", 32'(bus_n.timeout_pulse), 32'h1);
        chk("t4_drop_h_c5", 32'(bus_h.drop_pulse), 32'h0);
        chk("t4_tmo_h", 32'(bus_h.timeout_pulse), 32'h0);
        enable = 1'b0;
        tick();
        chk("t4_dis_pend_n", 32'(bus_n.pending), 32'h0);
        chk("t4_dis_tmo_n", 32'(bus_n.timeout_pulse), 32'h0);
        chk("t4_dis_viol_n", 32'(bus_n.viol_count), 32'd4);
        enable = 1'b1;

        // Held request, grant every third cycle
        req = 4'b1000;
        for (int k = 0; k < 9; k++) begin
            gnt = (k % 3 == 2) ? 4'b1000 : 4'b0000;
            tick();
        end
        gnt = '0;
        chk("t5_pend_gap", 32'(bus_h.pending), 32'h0);
        chk("t5_grant", 32'(bus_h.grant_count), 32'd6);
        chk("t5_viol", 32'(bus_h.viol_count), 32'd4);
        chk("t5_maxlat", 32'(bus_h.max_latency), 32'd7);
        clear = 1'b1;
        tick(); clear = 1'b0;
        chk("t5_clr_viol", 32'(bus_h.viol_count), 32'd0);
        chk("t5_clr_grant", 32'(bus_h.grant_count), 32'd0);
        chk("t5_clr_maxlat", 32'(bus_h.max_latency), 32'd0);
        chk("t5_clr_err_any", 32'(bus_h.err_any), 32'h0);
        chk("t5_clr_pend", 32'(bus_h.pending), 32'h8);
        req = '0; gnt = 4'b1000;
        tick(); gnt = '0;
        chk("t5_grant_after", 32'(bus_h.grant_count), 32'd1);
        chk("t5_maxlat_after", 32'(bus_h.max_latency), 32'd1);
        chk("t5_pend_after", 32'(bus_h.pending), 32'h0);

        // Reset mid-WAIT
        req = 4'b0001;
        tick(); chk("t6_pend", 32'(bus_h.pending), 32'h1);
        tick(); reset = 1'b1;
        tick(); reset = 1'b0; req = '0;
        chk("t6_rst_pend", 32'(bus_h.pending), 32'h0);
        chk("t6_rst_grant", 32'(bus_h.grant_count), 32'h0);
        chk("t6_rst_tmo", 32'(bus_h.timeout_pulse), 32'h0);
        tick();
        chk("t6_post_pend", 32'(bus_h.pending), 32'h0);
        chk("t6_post_pulses",
            32'(bus_h.timeout_pulse | bus_h.drop_pulse | bus_h.spurious_pulse), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
